// File: rtl/mshr_alloc_arb_pkg.sv
// Shared MSHR allocator / acquire arbiter types and parameter defaults.
package HasL1CacheParameters;

  localparam int unsigned NMshrDefault = 4;
  localparam int unsigned BlkWDefault  = 26;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } ArbStateE;

endpackage

// File: rtl/mshr_alloc_arb_rr_pick.sv
// Wrap-around priority pick: first set bit of req at or above start, wrapping past the top.
module rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] start,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] cand;
  logic            found;

  // N is a power of two, so IdxW-bit addition wraps modulo N.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = start;
    for (int unsigned i = 0; i < N; i++) begin
      cand = start + IdxW'(i);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mshr_alloc_arb.sv
// Miss allocation (primary/secondary MSHR steering) and round-robin TL-A acquire arbitration
// with lock-until-fire on the shared channel.
module mshr_alloc_arb
  import HasL1CacheParameters::*;
#(
  parameter int unsigned N_MSHR = NMshrDefault,
  parameter int unsigned BLK_W  = BlkWDefault
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_req_valid,
  input  logic [BLK_W-1:0]          i_req_blk_addr,
  output logic                      o_req_ready,
  output logic                      o_req_nack,
  output logic [N_MSHR-1:0]         o_pri_val,
  input  logic [N_MSHR-1:0]         i_pri_rdy,
  output logic [N_MSHR-1:0]         o_sec_val,
  input  logic [N_MSHR-1:0]         i_sec_rdy,
  input  logic [N_MSHR*BLK_W-1:0]   i_mshr_blk_addr,
  input  logic [N_MSHR-1:0]         i_mshr_busy,
  input  logic [N_MSHR-1:0]         i_acq_valid,
  output logic [N_MSHR-1:0]         o_acq_grant,
  output logic                      o_mem_a_valid,
  input  logic                      i_mem_a_ready,
  output logic [$clog2(N_MSHR)-1:0] o_acq_id
);

  localparam int unsigned IdxW = $clog2(N_MSHR);

  ArbStateE        state_q, state_d;
  logic [IdxW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] locked_q, locked_d;

  logic [N_MSHR-1:0] match;
  logic [N_MSHR-1:0] match_oh;
  logic [IdxW-1:0]   match_idx;
  logic              match_any;
  logic              sec_ok;

  logic [N_MSHR-1:0] pri_oh;
  logic [IdxW-1:0]   pri_idx;
  logic [N_MSHR-1:0] acq_oh;
  logic [IdxW-1:0]   acq_idx;

  // ---------------------------------------------------------------------------------------------
  // Allocation
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < N_MSHR; k++) begin
      match[k] = i_mshr_busy[k] && (i_mshr_blk_addr[k*BLK_W +: BLK_W] == i_req_blk_addr);
    end
  end

  always_comb begin
    match_any = |match;
    match_oh  = match & (~match + N_MSHR'(1));
    match_idx = '0;
    for (int k = N_MSHR - 1; k >= 0; k--) begin
      if (match[k]) begin
        match_idx = IdxW'(k);
      end
    end
    sec_ok = i_sec_rdy[match_idx];
  end

  rr_pick #(
    .N (N_MSHR)
  ) u_alloc_pick (
    .req    (i_pri_rdy),
    .start  (alloc_ptr_q),
    .onehot (pri_oh),
    .idx    (pri_idx)
  );

  // A matching MSHR owns the block: never fall back to a primary when its RPQ is full.
  always_comb begin
    o_pri_val = '0;
    o_sec_val = '0;
    if (reset && i_req_valid) begin
      if (match_any) begin
        if (sec_ok) begin
          o_sec_val = match_oh;
        end
      end else begin
        o_pri_val = pri_oh;
      end
    end
    o_req_ready = (|o_pri_val) || (|o_sec_val);
    o_req_nack  = reset && i_req_valid && !o_req_ready;
  end

  assign alloc_ptr_d = (|o_pri_val) ? pri_idx + IdxW'(1) : alloc_ptr_q;

  // ---------------------------------------------------------------------------------------------
  // Acquire arbiter
  // ---------------------------------------------------------------------------------------------
  rr_pick #(
    .N (N_MSHR)
  ) u_acq_pick (
    .req    (i_acq_valid),
    .start  (rr_ptr_q),
    .onehot (acq_oh),
    .idx    (acq_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      alloc_ptr_q <= '0;
      rr_ptr_q    <= '0;
      locked_q    <= '0;
    end else begin
      state_q     <= state_d;
      alloc_ptr_q <= alloc_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    locked_d = locked_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (o_mem_a_valid) begin
          if (i_mem_a_ready) begin
            rr_ptr_d = o_acq_id + IdxW'(1);
          end else begin
            state_d  = ARB_LOCK;
            locked_d = o_acq_id;
          end
        end
      end
      ARB_LOCK: begin
        // A dropped request while locked is abandoned without advancing the rotation.
        if (!i_acq_valid[locked_q]) begin
          state_d = ARB_IDLE;
        end else if (i_mem_a_ready) begin
          rr_ptr_d = locked_q + IdxW'(1);
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_acq_grant   = '0;
    o_acq_id      = '0;
    o_mem_a_valid = 1'b0;
    if (reset) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (|i_acq_valid) begin
            o_acq_grant   = acq_oh;
            o_acq_id      = acq_idx;
            o_mem_a_valid = 1'b1;
          end
        end
        ARB_LOCK: begin
          if (i_acq_valid[locked_q]) begin
            o_acq_grant   = N_MSHR'(1) << locked_q;
            o_acq_id      = locked_q;
            o_mem_a_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mshr_alloc_arb.sv
// Randomized and directed bench for mshr_alloc_arb against a cycle-level behavioural model.
module tb_mshr_alloc_arb;

  localparam int N = 4;
  localparam int W = 26;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             i_req_valid = 1'b0;
  logic [W-1:0]     i_req_blk_addr = '0;
  logic             o_req_ready;
  logic             o_req_nack;
  logic [N-1:0]     o_pri_val;
  logic [N-1:0]     i_pri_rdy = '0;
  logic [N-1:0]     o_sec_val;
  logic [N-1:0]     i_sec_rdy = '0;
  logic [N*W-1:0]   i_mshr_blk_addr = '0;
  logic [N-1:0]     i_mshr_busy = '0;
  logic [N-1:0]     i_acq_valid = '0;
  logic [N-1:0]     o_acq_grant;
  logic             o_mem_a_valid;
  logic             i_mem_a_ready = 1'b0;
  logic [1:0]       o_acq_id;

  always #5 clock = ~clock;

  mshr_alloc_arb #(
    .N_MSHR (N),
    .BLK_W  (W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_req_valid     (i_req_valid),
    .i_req_blk_addr  (i_req_blk_addr),
    .o_req_ready     (o_req_ready),
    .o_req_nack      (o_req_nack),
    .o_pri_val       (o_pri_val),
    .i_pri_rdy       (i_pri_rdy),
    .o_sec_val       (o_sec_val),
    .i_sec_rdy       (i_sec_rdy),
    .i_mshr_blk_addr (i_mshr_blk_addr),
    .i_mshr_busy     (i_mshr_busy),
    .i_acq_valid     (i_acq_valid),
    .o_acq_grant     (o_acq_grant),
    .o_mem_a_valid   (o_mem_a_valid),
    .i_mem_a_ready   (i_mem_a_ready),
    .o_acq_id        (o_acq_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: next-alloc slot, rotation start, and current channel owner (-1 = none).
  int m_alloc = 0;
  int m_rr    = 0;
  int m_owner = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_alloc = 0;
    m_rr    = 0;
    m_owner = -1;
  endtask

  task automatic set_mshr(input int k, input logic busy, input logic [W-1:0] addr);
    i_mshr_busy[k]              = busy;
    i_mshr_blk_addr[k*W +: W]   = addr;
  endtask

  // One clock: compare outputs at negedge, advance model at posedge, return at posedge+1.
  task automatic cycle(input string tag);
    logic [N-1:0] e_pri, e_sec, e_grant;
    logic         e_ready, e_nack, e_av;
    int           e_id, mk, win_a, win, idx;
    e_pri = '0; e_sec = '0; e_grant = '0;
    e_ready = 1'b0; e_nack = 1'b0; e_av = 1'b0;
    e_id = 0; mk = -1; win_a = -1; win = -1;
    @(negedge clock);
    if (reset) begin
      if (i_req_valid) begin
        for (int k = 0; k < N; k++) begin
          if (mk < 0 && i_mshr_busy[k] && i_mshr_blk_addr[k*W +: W] == i_req_blk_addr) mk = k;
        end
        if (mk >= 0) begin
          if (i_sec_rdy[mk]) e_sec[mk] = 1'b1;
        end else begin
          for (int j = 0; j < N; j++) begin
            idx = (m_alloc + j) % N;
            if (win_a < 0 && i_pri_rdy[idx]) win_a = idx;
          end
          if (win_a >= 0) e_pri[win_a] = 1'b1;
        end
        e_ready = (e_pri != 0) || (e_sec != 0);
        e_nack  = !e_ready;
      end
      if (m_owner >= 0) begin
        if (i_acq_valid[m_owner]) win = m_owner;
      end else begin
        for (int j = 0; j < N; j++) begin
          idx = (m_rr + j) % N;
          if (win < 0 && i_acq_valid[idx]) win = idx;
        end
      end
      if (win >= 0) begin
        e_grant[win] = 1'b1;
        e_av         = 1'b1;
        e_id         = win;
      end
    end
    check_val({tag, ".pri"},   32'(o_pri_val),     32'(e_pri));
    check_val({tag, ".sec"},   32'(o_sec_val),     32'(e_sec));
    check_val({tag, ".ready"}, 32'(o_req_ready),   32'(e_ready));
    check_val({tag, ".nack"},  32'(o_req_nack),    32'(e_nack));
    check_val({tag, ".grant"}, 32'(o_acq_grant),   32'(e_grant));
    check_val({tag, ".aval"},  32'(o_mem_a_valid), 32'(e_av));
    check_val({tag, ".id"},    32'(o_acq_id),      32'(e_id));
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      if (win_a >= 0) m_alloc = (win_a + 1) % N;
      if (win >= 0 && i_mem_a_ready) begin
        m_rr    = (win + 1) % N;
        m_owner = -1;
      end else if (win >= 0) begin
        m_owner = win;
      end else begin
        m_owner = -1;
      end
    end
    #1;
  endtask

  initial begin
    // Outputs must stay quiet under reset even with everything requesting.
    i_req_valid = 1'b1;
    i_pri_rdy   = 4'b1111;
    i_acq_valid = 4'b1111;
    repeat (2) cycle("rst");
    reset       = 1'b1;
    i_req_valid = 1'b0;
    i_acq_valid = '0;

    // Three back-to-back primaries, then a fourth proves the pointer sits at 3.
    i_req_valid = 1'b1;
    i_req_blk_addr = 26'h10; cycle("pri0");
    i_req_blk_addr = 26'h20; cycle("pri1");
    i_req_blk_addr = 26'h30; cycle("pri2");
    i_req_blk_addr = 26'h40; cycle("pri3");
    i_req_valid = 1'b0;
    cycle("idle");

    // Secondary merge then full-RPQ nack.
    set_mshr(2, 1'b1, 26'h20);
    i_sec_rdy = 4'b0100;
    i_req_valid = 1'b1;
    i_req_blk_addr = 26'h20; cycle("sec");
    i_sec_rdy = 4'b0000;     cycle("secnack");

    // No idle MSHR for a fresh block.
    i_pri_rdy = 4'b0000;
    i_req_blk_addr = 26'h55; cycle("prinack");
    i_req_valid = 1'b0;
    set_mshr(2, 1'b0, 26'h0);

    // Round robin with every beat accepted.
    i_acq_valid   = 4'b1111;
    i_mem_a_ready = 1'b1;
    repeat (4) cycle("rr");

    // Locked grant while memory stalls, then rotation moves on.
    i_acq_valid   = 4'b0011;
    i_mem_a_ready = 1'b0;
    repeat (3) cycle("lock");
    i_mem_a_ready = 1'b1;
    cycle("lockfire");
    cycle("next");

    // Asynchronous reset during a lock held by a non-zero index.
    i_acq_valid   = 4'b1100;
    i_mem_a_ready = 1'b0;
    cycle("prelock");
    i_req_valid = 1'b1;
    i_pri_rdy   = 4'b1111;
    #2 reset = 1'b0;
    #1;
    check_val("arst.grant", 32'(o_acq_grant),   32'd0);
    check_val("arst.aval",  32'(o_mem_a_valid), 32'd0);
    check_val("arst.id",    32'(o_acq_id),      32'd0);
    check_val("arst.pri",   32'(o_pri_val),     32'd0);
    check_val("arst.ready", 32'(o_req_ready),   32'd0);
    check_val("arst.nack",  32'(o_req_nack),    32'd0);
    model_reset();
    cycle("arsthold");
    reset         = 1'b1;
    i_req_valid   = 1'b0;
    i_acq_valid   = 4'b1111;
    i_mem_a_ready = 1'b1;
    @(negedge clock);
    check_val("arst.first", 32'(o_acq_grant), 32'b0001);
    @(posedge clock);
    m_rr = 1;
    #1;

    // Random traffic over a small address pool so matches are frequent.
    for (int c = 0; c < 800; c++) begin
      i_req_valid    = ($urandom_range(0, 3) != 0);
      i_req_blk_addr = W'($urandom_range(0, 5));
      i_pri_rdy      = N'($urandom);
      i_sec_rdy      = N'($urandom);
      i_mshr_busy    = N'($urandom);
      for (int k = 0; k < N; k++) i_mshr_blk_addr[k*W +: W] = W'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) i_acq_valid = N'($urandom);
      i_mem_a_ready = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) != 0);
      cycle("rand");
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mshr_alloc_arb.md
MSHR_ALLOC_ARB -- requirements
Module: mshr_alloc_arb

Interface
REQ-001 SHALL have parameter N_MSHR, default 4, meaning number of MSHRs managed (power of two, ≥2).
REQ-002 SHALL have parameter BLK_W, default 26, meaning block-address width (paddrBits minus blockOffBits).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port i_req_valid, input, 1, meaning a miss request is offered.
REQ-006 SHALL have port i_req_blk_addr, input, BLK_W, meaning the block address of the offered miss.
REQ-007 SHALL have port o_req_ready, output, 1, meaning the miss is accepted by an MSHR this cycle.
REQ-008 SHALL have port o_req_nack, output, 1, meaning the miss is rejected this cycle and must be replayed.
REQ-009 SHALL have port o_pri_val, output, N_MSHR, meaning one-hot primary allocation strobe.
REQ-010 SHALL have port i_pri_rdy, input, N_MSHR, meaning each MSHR is idle and can take a primary.
REQ-011 SHALL have port o_sec_val, output, N_MSHR, meaning one-hot secondary merge strobe.
REQ-012 SHALL have port i_sec_rdy, input, N_MSHR, meaning each MSHR can take a secondary (RPQ not full, not yet past refill).
REQ-013 SHALL have port i_mshr_blk_addr, input, N_MSHR*BLK_W, meaning each MSHR's block address, entry k at [k*BLK_W +: BLK_W].
REQ-014 SHALL have port i_mshr_busy, input, N_MSHR, meaning each MSHR holds a live block address.
REQ-015 SHALL have port i_acq_valid, input, N_MSHR, meaning each MSHR requests the shared TL-A acquire channel.
REQ-016 SHALL have port o_acq_grant, output, N_MSHR, meaning one-hot owner of the acquire channel.
REQ-017 SHALL have port o_mem_a_valid, output, 1, meaning the acquire channel is valid toward memory.
REQ-018 SHALL have port i_mem_a_ready, input, 1, meaning memory accepts the acquire beat.
REQ-019 SHALL have port o_acq_id, output, $clog2(N_MSHR), meaning the index of the granted MSHR (drives the TL-A source field).

Function
REQ-020 SHALL compute match[k] = i_mshr_busy[k] && (entry k address == i_req_blk_addr), combinationally.
REQ-021 SHALL, when i_req_valid and any match, assert o_sec_val only at the lowest matching index, and only if i_sec_rdy at that index is 1.
REQ-022 SHALL, when i_req_valid and a match exists but i_sec_rdy at the matched index is 0, assert o_req_nack and assert no strobe.
REQ-023 SHALL, when i_req_valid and no match, assert o_pri_val at the first index with i_pri_rdy=1, searching upward from alloc_ptr with wrap-around.
REQ-024 SHALL, when i_req_valid, no match and i_pri_rdy is all-zero, assert o_req_nack.
REQ-025 SHALL drive o_req_ready = |o_pri_val | |o_sec_val|, with o_req_ready and o_req_nack mutually exclusive, both 0 when i_req_valid=0.
REQ-026 SHALL load alloc_ptr with (allocated index+1) mod N_MSHR on each primary allocation, and leave it unchanged otherwise.
REQ-027 SHALL run the acquire arbiter FSM with states ARB_IDLE and ARB_LOCK.
REQ-028 SHALL, in ARB_IDLE with any i_acq_valid, round-robin select from rr_ptr and drive o_acq_grant, o_acq_id and o_mem_a_valid=1 in the same cycle.
REQ-029 SHALL, in ARB_IDLE, on fire (o_mem_a_valid && i_mem_a_ready), set rr_ptr=(winner+1) mod N_MSHR and remain in ARB_IDLE.
REQ-030 SHALL, in ARB_IDLE with o_mem_a_valid=1 and no fire, register the winner and go to ARB_LOCK.
REQ-031 SHALL, in ARB_LOCK, hold the grant to the locked index regardless of other requesters, with o_mem_a_valid = i_acq_valid[locked].
REQ-032 SHALL, in ARB_LOCK, on fire update rr_ptr as in REQ-029 and return to ARB_IDLE.
REQ-033 SHALL, in ARB_LOCK, if i_acq_valid[locked] drops (protocol violation), return to ARB_IDLE without updating rr_ptr.
REQ-034 SHALL hold o_acq_grant at zero and o_mem_a_valid at zero when no requester is valid.

Reset
REQ-035 SHALL, while reset=0, force FSM=ARB_IDLE, alloc_ptr=0, rr_ptr=0 and locked index=0, with every output at 0 and no strobe asserted.
REQ-036 SHALL, on reset assertion mid-lock, abandon the lock immediately, asynchronously, and not replay it.

Structure
REQ-037 SHALL place ArbStateE and the N_MSHR/BLK_W defaults in package HasL1CacheParameters.
REQ-038 SHALL implement the wrap-around priority pick as one sub-module rr_pick (inputs: request vector and start pointer; outputs: one-hot and index), instanced twice, for allocation and for acquire.

Verification
REQ-039 SHALL cover this scenario: i_mshr_busy=0, i_pri_rdy=4'b1111, three back-to-back misses to 0x10, 0x20, 0x30 -> o_pri_val = 0001, 0010, 0100, and alloc_ptr ends at 3.
REQ-040 SHALL cover this scenario: MSHR2 busy with 0x20, i_sec_rdy[2]=1, miss to 0x20 -> o_sec_val=0100, o_pri_val=0; then i_sec_rdy[2]=0 -> o_req_nack=1.
REQ-041 SHALL cover this scenario: i_pri_rdy=0000, miss to a non-matching address -> o_req_nack=1, o_req_ready=0.
REQ-042 SHALL cover this scenario: i_acq_valid=1111, i_mem_a_ready=1 for four cycles -> grant order 0,1,2,3.
REQ-043 SHALL cover this scenario: i_acq_valid=0011, i_mem_a_ready=0 for three cycles then 1 -> grant stays at 0001 throughout, then moves to 0010.
REQ-044 SHALL cover this scenario: reset asserted while in ARB_LOCK -> all outputs 0 within the same cycle, and the next grant after release goes to index 0.
